branch_resolve_unit: RTL and testbench

Parametrised successor to the decode-stage branch condition check of the pipelined MIPS. It evaluates an extended set of branch conditions on forwarded operands and waits for late operands through a stall handshake. It holds a 2-bit-counter branch history table (BHT) that drives the fetch-stage prediction and compares each outcome against the carried prediction. On a misprediction it raises a registered multi-cycle flush.

---
 rtl/branch_resolve_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decode-stage branch resolution with operand stall,
// 2-bit BHT prediction/training, mispredict detection and multi-cycle flush.
module branch_resolve_unit #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned PC_W      = 16,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              predict_taken,
   input  logic              res_valid,
   input  logic [2:0]        res_cmd,
   input  logic [PC_W-1:0]   res_pc,
   input  logic              res_pred,
   input  logic [DATA_W-1:0] reg1,
   input  logic [DATA_W-1:0] reg2,
   input  logic              operand_ready,
   output logic              stall,
   output logic              br_cond,
   output logic              resolved,
   output logic              mispredict,
   output logic              flush,
   output logic [CNT_W-1:0]  taken_cnt
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   localparam logic [2:0] CMD_NONE = 3'd0;
   localparam logic [2:0] CMD_JUMP = 3'd1;
   localparam logic [2:0] CMD_BNE  = 3'd2;
   localparam logic [2:0] CMD_BEZ  = 3'd3;
   localparam logic [2:0] CMD_BEQ  = 3'd4;
   localparam logic [2:0] CMD_BLTZ = 3'd5;
   localparam logic [2:0] CMD_BGEZ = 3'd6;
   localparam logic [2:0] CMD_BNEZ = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               br_cond_q, br_cond_d;
   logic               resolved_q, resolved_d;
   logic               mispredict_q, mispredict_d;
   logic               flush_q, flush_d;
   logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
   logic [2:0]         lat_cmd_q, lat_cmd_d;
   logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
   logic               lat_pred_q, lat_pred_d;
   logic [1:0]         bht_q [ENTRIES];

   logic               stall_c;
   logic               do_res;
   logic [2:0]         ev_cmd;
   logic [IDX_W-1:0]   ev_idx;
   logic               ev_pred;
   logic               taken_c;
   logic [1:0]         bht_cur;
   logic [1:0]         bht_upd;
   logic               unused_pc_bits;

   // Branch condition evaluation at full operand width.
   function automatic logic eval_cond(input logic [2:0]        cmd,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
      logic t;
      t = 1'b0;
      case (cmd)
         CMD_JUMP: t = 1'b1;
         CMD_BNE:  t = (a != b);
         CMD_BEZ:  t = (a == '0);
         CMD_BEQ:  t = (a == b);
         CMD_BLTZ: t = a[DATA_W-1];
         CMD_BGEZ: t = ~a[DATA_W-1];
         CMD_BNEZ: t = (a != '0);
         default:  t = 1'b0;
      endcase
      return t;
   endfunction

   // Next-state, resolve decision, counter and BHT-entry update.
   always_comb begin
      state_d      = state_q;
      br_cond_d    = br_cond_q;
      resolved_d   = 1'b0;
      mispredict_d = 1'b0;
      flush_d      = flush_q;
      flush_cnt_d  = flush_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      lat_cmd_d    = lat_cmd_q;
      lat_idx_d    = lat_idx_q;
      lat_pred_d   = lat_pred_q;
      stall_c      = 1'b0;
      do_res       = 1'b0;
      ev_cmd       = res_cmd;
      ev_idx       = res_pc[IDX_W-1:0];
      ev_pred      = res_pred;
      taken_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (res_valid && (res_cmd != CMD_NONE)) begin
               if (operand_ready) begin
                  do_res = 1'b1;
               end else begin
                  stall_c    = 1'b1;
                  lat_cmd_d  = res_cmd;
                  lat_idx_d  = res_pc[IDX_W-1:0];
                  lat_pred_d = res_pred;
                  state_d    = ST_WAIT_OPS;
               end
            end
         end
         ST_WAIT_OPS: begin
            ev_cmd  = lat_cmd_q;
            ev_idx  = lat_idx_q;
            ev_pred = lat_pred_q;
            if (operand_ready) begin
               do_res = 1'b1;
            end else begin
               stall_c = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == '0) begin
               flush_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      bht_cur = bht_q[ev_idx];
      bht_upd = bht_cur;

      if (do_res) begin
         taken_c      = eval_cond(ev_cmd, reg1, reg2);
         br_cond_d    = taken_c;
         resolved_d   = 1'b1;
         mispredict_d = (taken_c != ev_pred);
         if (taken_c) begin
            if (bht_cur != 2'b11) begin
               bht_upd = bht_cur + 2'd1;
            end
            if (taken_cnt_q != '1) begin
               taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
         end else begin
            if (bht_cur != 2'b00) begin
               bht_upd = bht_cur - 2'd1;
            end
         end
         if (mispredict_d) begin
            state_d     = ST_FLUSH;
            flush_d     = 1'b1;
            flush_cnt_d = FC_W'(FLUSH_CYC - 1);
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output, counter and latched-instruction registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         br_cond_q    <= 1'b0;
         resolved_q   <= 1'b0;
         mispredict_q <= 1'b0;
         flush_q      <= 1'b0;
         flush_cnt_q  <= '0;
         taken_cnt_q  <= '0;
         lat_cmd_q    <= 3'd0;
         lat_idx_q    <= '0;
         lat_pred_q   <= 1'b0;
      end else begin
         br_cond_q    <= br_cond_d;
         resolved_q   <= resolved_d;
         mispredict_q <= mispredict_d;
         flush_q      <= flush_d;
         flush_cnt_q  <= flush_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
         lat_cmd_q    <= lat_cmd_d;
         lat_idx_q    <= lat_idx_d;
         lat_pred_q   <= lat_pred_d;
      end
   end

   // Branch history table: reset to weakly not-taken, train on resolve.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (do_res) begin
         bht_q[ev_idx] <= bht_upd;
      end
   end

   // Fetch lookup reads the registered table, so a same-cycle update is not visible.
   assign predict_taken  = bht_q[fetch_pc[IDX_W-1:0]][1];
   assign stall          = stall_c;
   assign br_cond        = br_cond_q;
   assign resolved       = resolved_q;
   assign mispredict     = mispredict_q;
   assign flush          = flush_q;
   assign taken_cnt      = taken_cnt_q;
   assign unused_pc_bits = ^{fetch_pc, res_pc};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: two instances (FLUSH_CYC=1/CNT_W=16 and
// FLUSH_CYC=3/CNT_W=2) share stimulus and are checked against a behavioural model.
module tb_branch_resolve_unit;

   localparam logic [2:0] NONE = 3'd0, JUMP = 3'd1, BNE = 3'd2, BEZ = 3'd3;
   localparam logic [2:0] BEQ = 3'd4, BLTZ = 3'd5, BGEZ = 3'd6, BNEZ = 3'd7;

   logic        clk, rst;
   logic [15:0] fetch_pc, res_pc, reg1, reg2;
   logic [2:0]  res_cmd;
   logic        res_valid, res_pred, operand_ready;

   logic        pt0, st0, bc0, rs0, mp0, fl0;
   logic [15:0] tc0;
   logic        pt1, st1, bc1, rs1, mp1, fl1;
   logic [1:0]  tc1;

   int checks = 0;
   int errors = 0;

   // Behavioural model state, one slot per instance.
   int m_bht [2][16];
   int m_cnt [2];
   int m_fleft [2];
   bit m_wait [2];
   bit m_br [2], m_res [2], m_mis [2];
   int m_lcmd [2], m_lidx [2];
   bit m_lpred [2];

   branch_resolve_unit dut0 (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt0),
      .res_valid(res_valid), .res_cmd(res_cmd), .res_pc(res_pc), .res_pred(res_pred),
      .reg1(reg1), .reg2(reg2), .operand_ready(operand_ready), .stall(st0),
      .br_cond(bc0), .resolved(rs0), .mispredict(mp0), .flush(fl0), .taken_cnt(tc0)
   );

   branch_resolve_unit #(.FLUSH_CYC(3), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt1),
      .res_valid(res_valid), .res_cmd(res_cmd), .res_pc(res_pc), .res_pred(res_pred),
      .reg1(reg1), .reg2(reg2), .operand_ready(operand_ready), .stall(st1),
      .br_cond(bc1), .resolved(rs1), .mispredict(mp1), .flush(fl1), .taken_cnt(tc1)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   function automatic int fcyc(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int cmax(int d);
      return (d == 0) ? 65535 : 3;
   endfunction

   function automatic bit model_taken(int cmd, logic [15:0] a, logic [15:0] b);
      case (cmd)
         1: return 1'b1;
         2: return a != b;
         3: return a == 16'd0;
         4: return a == b;
         5: return $signed(a) < 0;
         6: return $signed(a) >= 0;
         7: return a != 16'd0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit exp_stall(int d);
      if (m_fleft[d] > 0) return 1'b0;
      if (m_wait[d]) return !operand_ready;
      return res_valid && (res_cmd != NONE) && !operand_ready;
   endfunction

   function automatic logic [5:0] exp_vec(int d);
      logic [5:0] e;
      e = {m_br[d], m_res[d], m_mis[d], m_fleft[d] > 0, exp_stall(d),
           m_bht[d][int'(fetch_pc[3:0])] >= 2};
      return e;
   endfunction

   // Model advance at each rising edge from the inputs of the ending cycle.
   task automatic model_step();
      bit go, t, pred;
      int cmd, idx;
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            for (int k = 0; k < 16; k++) m_bht[d][k] = 1;
            m_cnt[d] = 0; m_fleft[d] = 0; m_wait[d] = 0;
            m_br[d] = 0; m_res[d] = 0; m_mis[d] = 0;
            m_lcmd[d] = 0; m_lidx[d] = 0; m_lpred[d] = 0;
         end else begin
            go = 0; cmd = 0; idx = 0; pred = 0;
            m_res[d] = 0; m_mis[d] = 0;
            if (m_fleft[d] > 0) begin
               m_fleft[d]--;
            end else if (m_wait[d]) begin
               if (operand_ready) begin
                  go = 1; cmd = m_lcmd[d]; idx = m_lidx[d]; pred = m_lpred[d]; m_wait[d] = 0;
               end
            end else if (res_valid && res_cmd != NONE) begin
               if (operand_ready) begin
                  go = 1; cmd = int'(res_cmd); idx = int'(res_pc[3:0]); pred = res_pred;
               end else begin
                  m_wait[d] = 1; m_lcmd[d] = int'(res_cmd); m_lidx[d] = int'(res_pc[3:0]);
                  m_lpred[d] = res_pred;
               end
            end
            if (go) begin
               t = model_taken(cmd, reg1, reg2);
               m_br[d] = t; m_res[d] = 1; m_mis[d] = (t != pred);
               if (t) begin
                  if (m_bht[d][idx] < 3) m_bht[d][idx]++;
                  if (m_cnt[d] < cmax(d)) m_cnt[d]++;
               end else if (m_bht[d][idx] > 0) begin
                  m_bht[d][idx]--;
               end
               if (t != pred) m_fleft[d] = fcyc(d);
            end
         end
      end
   endtask

   always @(posedge clk) model_step();

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] pc,
                        input logic p, input logic [15:0] a, input logic [15:0] b,
                        input logic rdy);
      res_valid = v; res_cmd = c; res_pc = pc; res_pred = p;
      reg1 = a; reg2 = b; operand_ready = rdy;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({bc0, rs0, mp0, fl0, st0} !== 5'b0) begin errors++; $display("FAIL reset_outs0 got %b exp 00000", {bc0, rs0, mp0, fl0, st0}); end
      checks++; if ({bc1, rs1, mp1, fl1, st1} !== 5'b0) begin errors++; $display("FAIL reset_outs1 got %b exp 00000", {bc1, rs1, mp1, fl1, st1}); end
      checks++; if (tc0 !== 16'd0 || tc1 !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", tc0, tc1); end
      for (int p = 0; p < 16; p++) begin
         fetch_pc = 16'(p); #1;
         checks++; if (pt0 !== 1'b0 || pt1 !== 1'b0) begin errors++; $display("FAIL reset_bht idx %0d got %b%b exp 00", p, pt0, pt1); end
      end
   endtask

   task automatic test_beq_mispredict();
      do_reset();
      fetch_pc = 16'h0003;
      drive(1, BEQ, 16'h0003, 0, 16'h1234, 16'h1234, 1); #1;
      checks++; if (pt0 !== 1'b0 || st0 !== 1'b0) begin errors++; $display("FAIL beq_pre pt/stall got %b%b exp 00", pt0, st0); end
      tick();
      checks++; if ({bc0, rs0, mp0, fl0} !== 4'b1111) begin errors++; $display("FAIL beq_res0 got %b exp 1111", {bc0, rs0, mp0, fl0}); end
      checks++; if ({bc1, rs1, mp1, fl1} !== 4'b1111) begin errors++; $display("FAIL beq_res1 got %b exp 1111", {bc1, rs1, mp1, fl1}); end
      checks++; if (pt0 !== 1'b1 || pt1 !== 1'b1) begin errors++; $display("FAIL beq_trained got %b%b exp 11", pt0, pt1); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if ({bc0, rs0, mp0, fl0} !== 4'b1000) begin errors++; $display("FAIL beq_after got %b exp 1000", {bc0, rs0, mp0, fl0}); end
      checks++; if (fl1 !== 1'b1) begin errors++; $display("FAIL beq_flush1_c2 got %b exp 1", fl1); end
      tick();
      checks++; if (fl1 !== 1'b1) begin errors++; $display("FAIL beq_flush1_c3 got %b exp 1", fl1); end
      tick();
      checks++; if (fl1 !== 1'b0) begin errors++; $display("FAIL beq_flush1_end got %b exp 0", fl1); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, BLTZ, 16'h0005, 1, 16'h8000, 16'h0000, 1);
      tick();
      checks++; if ({bc0, rs0, mp0} !== 3'b110 || tc0 !== 16'd1) begin errors++; $display("FAIL b2b_first got %b cnt %0d exp 110 cnt 1", {bc0, rs0, mp0}, tc0); end
      drive(1, BGEZ, 16'h0006, 1, 16'h7FFF, 16'h0000, 1);
      tick();
      checks++; if ({bc0, rs0, mp0} !== 3'b110 || tc0 !== 16'd2) begin errors++; $display("FAIL b2b_second got %b cnt %0d exp 110 cnt 2", {bc0, rs0, mp0}, tc0); end
      checks++; if (tc1 !== 2'd2 || rs1 !== 1'b1) begin errors++; $display("FAIL b2b_dut1 got cnt %0d res %b exp 2 1", tc1, rs1); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if (rs0 !== 1'b0 || bc0 !== 1'b1) begin errors++; $display("FAIL b2b_idle got res %b br %b exp 0 1", rs0, bc0); end
   endtask

   task automatic test_stall();
      do_reset();
      drive(1, BNE, 16'h0007, 0, 16'd5, 16'd5, 0); #1;
      checks++; if (st0 !== 1'b1 || st1 !== 1'b1) begin errors++; $display("FAIL stall_c1 got %b%b exp 11", st0, st1); end
      tick();
      res_cmd = NONE; res_pred = 1'b1; res_pc = 16'h000C; #1;
      checks++; if (st0 !== 1'b1 || rs0 !== 1'b0) begin errors++; $display("FAIL stall_c2 got st %b res %b exp 1 0", st0, rs0); end
      tick();
      checks++; if (st0 !== 1'b1 || rs0 !== 1'b0) begin errors++; $display("FAIL stall_c3 got st %b res %b exp 1 0", st0, rs0); end
      tick();
      operand_ready = 1'b1; #1;
      checks++; if (st0 !== 1'b0 || rs0 !== 1'b0) begin errors++; $display("FAIL stall_release got st %b res %b exp 0 0", st0, rs0); end
      tick();
      checks++; if ({bc0, rs0, mp0} !== 3'b010) begin errors++; $display("FAIL stall_resolve0 got %b exp 010", {bc0, rs0, mp0}); end
      checks++; if ({bc1, rs1, mp1} !== 3'b010) begin errors++; $display("FAIL stall_resolve1 got %b exp 010", {bc1, rs1, mp1}); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if (rs0 !== 1'b0 || st0 !== 1'b0) begin errors++; $display("FAIL stall_done got res %b st %b exp 0 0", rs0, st0); end
   endtask

   task automatic test_flush3();
      do_reset();
      fetch_pc = 16'h0009;
      drive(1, JUMP, 16'h0009, 0, 16'd0, 16'd0, 1);
      tick();
      checks++; if ({rs1, mp1, fl1} !== 3'b111) begin errors++; $display("FAIL fl3_start got %b exp 111", {rs1, mp1, fl1}); end
      drive(1, BEZ, 16'h0009, 1, 16'h0001, 16'd0, 1);
      tick();
      checks++; if ({rs1, mp1, fl1} !== 3'b001) begin errors++; $display("FAIL fl3_c2 got %b exp 001", {rs1, mp1, fl1}); end
      tick();
      checks++; if ({rs1, mp1, fl1} !== 3'b001) begin errors++; $display("FAIL fl3_c3 got %b exp 001", {rs1, mp1, fl1}); end
      checks++; if ({bc0, rs0, mp0, fl0, st0, pt0} !== exp_vec(0)) begin errors++; $display("FAIL fl3_dut0_model got %b exp %b", {bc0, rs0, mp0, fl0, st0, pt0}, exp_vec(0)); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if ({rs1, fl1} !== 2'b00) begin errors++; $display("FAIL fl3_end got %b exp 00", {rs1, fl1}); end
      checks++; if (pt1 !== 1'b1) begin errors++; $display("FAIL fl3_bht_kept got %b exp 1", pt1); end
      checks++; if ({bc0, rs0, mp0, fl0, st0, pt0} !== exp_vec(0)) begin errors++; $display("FAIL fl3_dut0_end got %b exp %b", {bc0, rs0, mp0, fl0, st0, pt0}, exp_vec(0)); end
   endtask

   task automatic test_same_index();
      do_reset();
      fetch_pc = 16'h000A;
      drive(1, BEQ, 16'h000A, 0, 16'd7, 16'd7, 1); #1;
      checks++; if (pt0 !== 1'b0) begin errors++; $display("FAIL same_idx_pre got %b exp 0", pt0); end
      tick();
      checks++; if (pt0 !== 1'b1) begin errors++; $display("FAIL same_idx_post got %b exp 1", pt0); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      for (int n = 0; n < 5; n++) begin
         drive(1, BEQ, 16'h001A, 1, 16'd7, 16'd7, 1);
         tick();
      end
      checks++; if (tc0 !== 16'd6 || tc1 !== 2'd3) begin errors++; $display("FAIL same_idx_cnt got %0d/%0d exp 6/3", tc0, tc1); end
      checks++; if (pt0 !== 1'b1 || mp0 !== 1'b0) begin errors++; $display("FAIL same_idx_sat got pt %b mp %b exp 1 0", pt0, mp0); end
      drive(1, BNE, 16'h000A, 1, 16'd7, 16'd7, 1);
      tick();
      checks++; if (pt0 !== 1'b1 || mp0 !== 1'b1) begin errors++; $display("FAIL same_idx_dec1 got pt %b mp %b exp 1 1", pt0, mp0); end
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      drive(1, BNE, 16'h000A, 0, 16'd7, 16'd7, 1);
      tick();
      checks++; if (pt0 !== 1'b0 || mp0 !== 1'b0) begin errors++; $display("FAIL same_idx_dec2 got pt %b mp %b exp 0 0", pt0, mp0); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, JUMP, 16'h0002, 1, 16'd0, 16'd0, 1);
      tick();
      drive(1, BNE, 16'h0002, 0, 16'd1, 16'd1, 0);
      tick();
      checks++; if (st0 !== 1'b1 || tc0 !== 16'd1) begin errors++; $display("FAIL rmid_wait got st %b cnt %0d exp 1 1", st0, tc0); end
      rst = 1'b0;
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if (st0 !== 1'b0 || tc0 !== 16'd0 || rs0 !== 1'b0) begin errors++; $display("FAIL rmid_state got st %b cnt %0d res %b exp 0 0 0", st0, tc0, rs0); end
      rst = 1'b1;
      for (int p = 0; p < 16; p++) begin
         fetch_pc = 16'(p); #1;
         checks++; if (pt0 !== 1'b0 || pt1 !== 1'b0) begin errors++; $display("FAIL rmid_bht idx %0d got %b%b exp 00", p, pt0, pt1); end
      end
      operand_ready = 1'b1;
      tick();
      checks++; if (rs0 !== 1'b0 || rs1 !== 1'b0) begin errors++; $display("FAIL rmid_nopulse got %b%b exp 00", rs0, rs1); end
      drive(1, JUMP, 16'h0004, 0, 16'd0, 16'd0, 1);
      tick();
      checks++; if (fl1 !== 1'b1) begin errors++; $display("FAIL rmid_flush_start got %b exp 1", fl1); end
      rst = 1'b0;
      drive(0, NONE, 0, 0, 0, 0, 0);
      tick();
      checks++; if ({fl0, fl1, mp0, mp1} !== 4'b0000) begin errors++; $display("FAIL rmid_flush got %b exp 0000", {fl0, fl1, mp0, mp1}); end
      rst = 1'b1;
   endtask

   task automatic test_random();
      logic [15:0] a;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 59) != 0);
         res_valid = ($urandom_range(0, 3) != 0);
         res_cmd = 3'($urandom);
         res_pc = {12'($urandom), 4'($urandom_range(0, 3))};
         fetch_pc = {12'($urandom), 4'($urandom_range(0, 3))};
         res_pred = 1'($urandom);
         operand_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: a = 16'd0;
            1: a = 16'h8000 | 16'($urandom);
            default: a = 16'($urandom);
         endcase
         reg1 = a;
         reg2 = ($urandom_range(0, 1) != 0) ? a : 16'($urandom);
         #1;
         checks++; if ({bc0, rs0, mp0, fl0, st0, pt0} !== exp_vec(0)) begin errors++; $display("FAIL rand_dut0 cyc %0d got %b exp %b", n, {bc0, rs0, mp0, fl0, st0, pt0}, exp_vec(0)); end
         checks++; if ({bc1, rs1, mp1, fl1, st1, pt1} !== exp_vec(1)) begin errors++; $display("FAIL rand_dut1 cyc %0d got %b exp %b", n, {bc1, rs1, mp1, fl1, st1, pt1}, exp_vec(1)); end
         checks++; if (int'(tc0) != m_cnt[0] || int'(tc1) != m_cnt[1]) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d/%0d exp %0d/%0d", n, tc0, tc1, m_cnt[0], m_cnt[1]); end
         tick();
      end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      fetch_pc = 16'd0;
      drive(0, NONE, 0, 0, 0, 0, 0);
      test_reset();
      test_beq_mispredict();
      test_back_to_back();
      test_stall();
      test_flush3();
      test_same_index();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
